cpu_controller: RTL and testbench
=================================

# cpu_controller

Instruction-sequencing controller for the 8-bit accumulator CPU. It is the driving end of the ALU interface: it walks each instruction through eight fixed phases and issues memory, IR, PC and accumulator strobes. It consumes the decoded `opcode` and the ALU `zero` flag, so that ALU results are latched in the correct phase. It sits between the instruction register and the datapath (memory, PC, accumulator).

## Interface
Parameters:
- `HALT_STICKY`, default 1: 1 means a `HLT` instruction parks the FSM in `HALTED` until reset. 0 means `halt` pulses for one cycle and the sequence continues.

Ports:
- `clk`, in, 1: single clock; all state updates on posedge.
- `rst`, in, 1: asynchronous, active-high reset.
- `opcode`, in, `opcode_t` (3): current IR opcode.
- `zero`, in, 1: ALU zero flag, which is (accum == 0).
- `mem_rd`, out, 1: memory read enable.
- `load_ir`, out, 1: instruction register load.
- `inc_pc`, out, 1: program counter increment.
- `load_pc`, out, 1: program counter load (jump).
- `load_ac`, out, 1: accumulator load from ALU `out`.
- `mem_wr`, out, 1: memory write enable.
- `halt`, out, 1: processor halted.
- `phase`, out, `phase_t` (3): current phase, for debug and formal checks.

## Operation
- Opcode encoding:
  - HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
  - `aluop` = ADD | AND | XOR | LDA.
- Phase FSM, one phase per cycle, fixed order: INST_ADDR(0) → INST_FETCH(1) → INST_LOAD(2) → IDLE(3) → OP_ADDR(4) → OP_FETCH(5) → ALU_OP(6) → STORE(7) → INST_ADDR.
- Extra state `HALTED`:
  - Entered from OP_ADDR when `opcode==HLT` and `HALT_STICKY=1`.
  - Exited only by `rst`.
  - `phase` reads 4 (OP_ADDR) while in HALTED.
- Outputs are combinational decode of state, `opcode` and `zero`. Every output is 0 unless listed for the current phase:
  - INST_ADDR: all outputs 0.
  - INST_FETCH: `mem_rd`.
  - INST_LOAD and IDLE: `mem_rd`, `load_ir`.
  - OP_ADDR: `inc_pc`; also `halt` if `opcode==HLT`.
  - OP_FETCH: `mem_rd` if `aluop`.
  - ALU_OP: `mem_rd` and `load_ac` if `aluop`; `inc_pc` if SKZ && `zero`; `load_pc` if JMP.
  - STORE: `mem_rd` and `load_ac` if `aluop`; `inc_pc` and `load_pc` if JMP; `mem_wr` if STO.
  - HALTED: only `halt`=1.
- `load_ac` spans ALU_OP and STORE, so the accumulator captures ALU `out`. The ALU's negedge output update falls inside that window.
- `zero` is sampled combinationally in ALU_OP only. A `zero` change in any other phase has no effect.
- `mem_wr` and `mem_rd` are never high together. STO is not an `aluop`, so this holds by construction. A failure of this property is a design error.

## Timing
- Reset (async): state = INST_ADDR immediately. All strobes and `halt` go to 0 and `phase` = 0 without waiting for a clock edge.
- Release of `rst`: the first posedge moves the FSM to INST_FETCH.
- One instruction takes exactly 8 cycles. `HALT_STICKY=0` keeps the 8-cycle cadence for HLT.
- HLT with `HALT_STICKY=1`: `halt` rises in OP_ADDR, then the next posedge enters HALTED and `halt` stays 1.
- `rst` asserted mid-instruction: the FSM aborts on the next simulation step with no partial strobes. Memory and registers are not rolled back.
- `opcode` must be stable from IDLE through STORE. The controller does not latch it.

## Structure
- Shared package `typedefs`:
  - `opcode_t` (existing).
  - New `phase_t` enum covering the 8 phases.
  - Constant `ALUOP_SET` or a function `is_aluop(opcode_t)`.
- `HALTED` is an internal encoding of the state register and is not part of `phase_t`.
- Sub-module `ctrl_decode`: purely combinational map from (phase, halted, opcode, zero) to the 7 strobes. It can be reused by the formal checker as a golden model.
- Top level holds the state register and the next-state logic.

## Test plan
- Reset then 8 clocks with `opcode`=ADD → `phase` goes 0..7 then back to 0. `mem_rd`=1 in phases 1,2,3,5,6,7. `load_ac`=1 in phases 6 and 7. `mem_wr`=0 throughout.
- `opcode`=SKZ, `zero`=1 → `inc_pc`=1 in phases 4 and 6. Repeat with `zero`=0 → `inc_pc`=1 in phase 4 only.
- `opcode`=JMP → `load_pc`=1 in phases 6 and 7, `inc_pc`=1 in phase 7, `load_ac`=0 throughout.
- `opcode`=STO → `mem_wr`=1 in phase 7 only, with `mem_rd`=0 in that phase.
- `opcode`=HLT, `HALT_STICKY`=1 → `halt`=1 from phase 4 onward for 20 or more cycles, all strobes 0 after entry to HALTED. Then `rst` → `phase`=0 and `halt`=0 asynchronously.
- Pulse `rst` mid-phase 6 with LDA → all outputs 0 immediately. Sequence restarts at INST_FETCH after release.

Source files
------------

// File: rtl/cpu_controller_pkg.sv
// Shared types for the accumulator CPU controller: opcodes, phases, FSM state.
package cpu_controller_pkg;

  localparam int unsigned OPCODE_W = 3;
  localparam int unsigned PHASE_W  = 3;
  localparam int unsigned STATE_W  = 4;

  typedef enum logic [OPCODE_W-1:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [PHASE_W-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  // Low three bits of the running states equal the phase code; HALTED sits above.
  typedef enum logic [STATE_W-1:0] {
    S_INST_ADDR  = 4'd0,
    S_INST_FETCH = 4'd1,
    S_INST_LOAD  = 4'd2,
    S_IDLE       = 4'd3,
    S_OP_ADDR    = 4'd4,
    S_OP_FETCH   = 4'd5,
    S_ALU_OP     = 4'd6,
    S_STORE      = 4'd7,
    S_HALTED     = 4'd8
  } state_t;

  function automatic logic is_aluop(input opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decode from (phase, halted, opcode, zero); reusable as a golden model.
module ctrl_decode
  import cpu_controller_pkg::*;
(
  input  phase_t  phase_i,
  input  logic    halted_i,
  input  opcode_t opcode_i,
  input  logic    zero_i,
  output logic    mem_rd_o,
  output logic    load_ir_o,
  output logic    inc_pc_o,
  output logic    load_pc_o,
  output logic    load_ac_o,
  output logic    mem_wr_o,
  output logic    halt_o
);

  logic alu_c;

  assign alu_c = is_aluop(opcode_i);

  always_comb begin
    mem_rd_o  = 1'b0;
    load_ir_o = 1'b0;
    inc_pc_o  = 1'b0;
    load_pc_o = 1'b0;
    load_ac_o = 1'b0;
    mem_wr_o  = 1'b0;
    halt_o    = 1'b0;
    if (halted_i) begin
      halt_o = 1'b1;
    end else begin
      case (phase_i)
        INST_FETCH: mem_rd_o = 1'b1;
        INST_LOAD, IDLE: begin
          mem_rd_o  = 1'b1;
          load_ir_o = 1'b1;
        end
        OP_ADDR: begin
          inc_pc_o = 1'b1;
          halt_o   = (opcode_i == HLT);
        end
        OP_FETCH: mem_rd_o = alu_c;
        // zero only matters here; it is ignored in every other phase
        ALU_OP: begin
          mem_rd_o  = alu_c;
          load_ac_o = alu_c;
          inc_pc_o  = (opcode_i == SKZ) && zero_i;
          load_pc_o = (opcode_i == JMP);
        end
        STORE: begin
          mem_rd_o  = alu_c;
          load_ac_o = alu_c;
          inc_pc_o  = (opcode_i == JMP);
          load_pc_o = (opcode_i == JMP);
          mem_wr_o  = (opcode_i == STO);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer with optional sticky HALTED state.
module cpu_controller
  import cpu_controller_pkg::*;
#(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic    clk,
  input  logic    rst,
  input  opcode_t opcode,
  input  logic    zero,
  output logic    mem_rd,
  output logic    load_ir,
  output logic    inc_pc,
  output logic    load_pc,
  output logic    load_ac,
  output logic    mem_wr,
  output logic    halt,
  output phase_t  phase
);

  state_t state_q, state_d;
  logic   halted_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_INST_ADDR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INST_ADDR:  state_d = S_INST_FETCH;
      S_INST_FETCH: state_d = S_INST_LOAD;
      S_INST_LOAD:  state_d = S_IDLE;
      S_IDLE:       state_d = S_OP_ADDR;
      S_OP_ADDR:    state_d = (HALT_STICKY && (opcode == HLT)) ? S_HALTED : S_OP_FETCH;
      S_OP_FETCH:   state_d = S_ALU_OP;
      S_ALU_OP:     state_d = S_STORE;
      S_STORE:      state_d = S_INST_ADDR;
      S_HALTED:     state_d = S_HALTED;
      default:      state_d = S_INST_ADDR;
    endcase
  end

  assign halted_c = (state_q == S_HALTED);
  assign phase    = halted_c ? OP_ADDR : phase_t'(state_q[PHASE_W-1:0]);

  ctrl_decode u_decode (
    .phase_i   (phase),
    .halted_i  (halted_c),
    .opcode_i  (opcode),
    .zero_i    (zero),
    .mem_rd_o  (mem_rd),
    .load_ir_o (load_ir),
    .inc_pc_o  (inc_pc),
    .load_pc_o (load_pc),
    .load_ac_o (load_ac),
    .mem_wr_o  (mem_wr),
    .halt_o    (halt)
  );

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: sticky and non-sticky instances against a phase-counting model.
module tb_cpu_controller;
  import cpu_controller_pkg::*;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  opcode_t opcode = ADD;
  logic    zero = 1'b0;

  logic   a_rd, a_ir, a_ipc, a_lpc, a_lac, a_wr, a_halt;
  phase_t a_ph;
  logic   b_rd, b_ir, b_ipc, b_lpc, b_lac, b_wr, b_halt;
  phase_t b_ph;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model: phase counters advanced by cycle count; sticky model freezes at 4 on HLT
  int m_ph  = 0;
  bit m_h   = 1'b0;
  int m_ph2 = 0;

  always #5 clk = ~clk;

  cpu_controller #(.HALT_STICKY(1'b1)) dut_a (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .mem_rd(a_rd), .load_ir(a_ir), .inc_pc(a_ipc), .load_pc(a_lpc),
    .load_ac(a_lac), .mem_wr(a_wr), .halt(a_halt), .phase(a_ph)
  );

  cpu_controller #(.HALT_STICKY(1'b0)) dut_b (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .mem_rd(b_rd), .load_ir(b_ir), .inc_pc(b_ipc), .load_pc(b_lpc),
    .load_ac(b_lac), .mem_wr(b_wr), .halt(b_halt), .phase(b_ph)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // expected {mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, halt}
  function automatic logic [6:0] expect_out(input int ph, input bit h, input opcode_t op, input bit z);
    bit alu, run;
    alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    run = !h;
    expect_out[6] = run && ((ph >= 1 && ph <= 3) || (ph >= 5 && alu));
    expect_out[5] = run && (ph == 2 || ph == 3);
    expect_out[4] = run && (ph == 4 || (ph == 6 && op == SKZ && z) || (ph == 7 && op == JMP));
    expect_out[3] = run && ph >= 6 && op == JMP;
    expect_out[2] = run && ph >= 6 && alu;
    expect_out[1] = run && ph == 7 && op == STO;
    expect_out[0] = h || (ph == 4 && op == HLT);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph  <= 0;
      m_h   <= 1'b0;
      m_ph2 <= 0;
    end else begin
      if (!m_h) begin
        if (m_ph == 4 && opcode == HLT) m_h <= 1'b1;
        else                            m_ph <= (m_ph + 1) % 8;
      end
      m_ph2 <= (m_ph2 + 1) % 8;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_strobes", {a_rd, a_ir, a_ipc, a_lpc, a_lac, a_wr, a_halt},
          expect_out(m_ph, m_h, opcode, zero));
      chk("a_phase", a_ph, m_ph);
      chk("b_strobes", {b_rd, b_ir, b_ipc, b_lpc, b_lac, b_wr, b_halt},
          expect_out(m_ph2, 1'b0, opcode, zero));
      chk("b_phase", b_ph, m_ph2);
      chk("rd_wr_excl", (a_rd & a_wr) | (b_rd & b_wr), 0);
    end
  end

  // Leaves the bench #1 after the posedge that holds phase 0.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Called #1 after a posedge at phase 0; records one bit per phase over 8 cycles.
  task automatic run_instr(input opcode_t op, input logic z,
                           output logic [7:0] rd, output logic [7:0] ipc,
                           output logic [7:0] lpc, output logic [7:0] lac,
                           output logic [7:0] wr, output logic [7:0] ha,
                           output logic [7:0] hb, output logic [7:0] ph_ok);
    opcode = op;
    zero   = z;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rd[i]    = a_rd;
      ipc[i]   = a_ipc;
      lpc[i]   = a_lpc;
      lac[i]   = a_lac;
      wr[i]    = a_wr;
      ha[i]    = a_halt;
      hb[i]    = b_halt;
      ph_ok[i] = (int'(b_ph) == i);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] rd, ipc, lpc, lac, wr, ha, hb, pk;
    int k;
    #1 chk_en = 1'b1;
    chk("reset_phase", a_ph, 0);
    chk("reset_strobes", {a_rd, a_ir, a_ipc, a_lpc, a_lac, a_wr, a_halt}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_instr(ADD, 1'b0, rd, ipc, lpc, lac, wr, ha, hb, pk);
    chk("add_phase_seq", pk, 8'hFF);
    chk("add_mem_rd", rd, 8'b1110_1110);
    chk("add_load_ac", lac, 8'b1100_0000);
    chk("add_mem_wr", wr, 8'h00);

    run_instr(SKZ, 1'b1, rd, ipc, lpc, lac, wr, ha, hb, pk);
    chk("skz_z1_inc_pc", ipc, 8'b0101_0000);
    run_instr(SKZ, 1'b0, rd, ipc, lpc, lac, wr, ha, hb, pk);
    chk("skz_z0_inc_pc", ipc, 8'b0001_0000);

    run_instr(JMP, 1'b0, rd, ipc, lpc, lac, wr, ha, hb, pk);
    chk("jmp_load_pc", lpc, 8'b1100_0000);
    chk("jmp_inc_pc", ipc, 8'b1001_0000);
    chk("jmp_load_ac", lac, 8'h00);

    run_instr(STO, 1'b1, rd, ipc, lpc, lac, wr, ha, hb, pk);
    chk("sto_mem_wr", wr, 8'b1000_0000);
    chk("sto_mem_rd", rd, 8'b0000_1110);

    // sticky halts from phase 4; non-sticky pulses once and keeps cadence
    run_instr(HLT, 1'b0, rd, ipc, lpc, lac, wr, ha, hb, pk);
    chk("hlt_sticky_halt", ha, 8'b1111_0000);
    chk("hlt_pulse_halt", hb, 8'b0001_0000);
    chk("hlt_pulse_cadence", pk, 8'hFF);
    chk("hlt_halted_strobes", {rd[7:5], ipc[7:5], lpc[7:5], lac[7:5], wr[7:5]}, 0);
    repeat (20) @(negedge clk);
    chk("halted_phase", a_ph, 4);
    chk("halted_halt", a_halt, 1);
    #2 rst = 1'b1;
    #1;
    chk("halt_async_rst_phase", a_ph, 0);
    chk("halt_async_rst_halt", a_halt, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // abort LDA in ALU_OP with an async reset
    opcode = LDA;
    repeat (6) @(posedge clk);
    #2;
    chk("lda_pre_rst_ld_ac", a_lac, 1);
    rst = 1'b1;
    #1;
    chk("lda_rst_strobes", {a_rd, a_ir, a_ipc, a_lpc, a_lac, a_wr, a_halt}, 0);
    chk("lda_rst_phase", a_ph, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("lda_restart_ph0", a_ph, 0);
    @(posedge clk);
    #1;
    chk("lda_restart_ph1", a_ph, 1);
    chk("lda_restart_rd", a_rd, 1);
    do_reset();

    // random opcodes per instruction, random zero per cycle, random async resets
    k = 0;
    for (int c = 0; c < 3000; c++) begin
      if (k == 0) opcode = opcode_t'($urandom_range(0, 7));
      zero = 1'(($urandom_range(0, 1)));
      if ($urandom_range(0, 59) == 0) begin
        #($urandom_range(1, 7));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        k = 0;
      end else begin
        @(posedge clk);
        #1;
        k = (k + 1) % 8;
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
